// File: rtl/nou_rr_grant_scheduler.sv
// rtl/nou_rr_grant_scheduler.sv - round-robin grant scheduler with burst hold for a shared NOU slot
// Optional priority masking is enabled by defining NOU_SCHED_PRIO_EN.
module nou_rr_grant_scheduler #(
    parameter int NUM_REQ     = 8,
    parameter int MAX_BURST   = 4,
    parameter int INDEX_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_vec,
`ifdef NOU_SCHED_PRIO_EN
    input  logic [NUM_REQ-1:0]     prio_vec,
`endif
    output logic                   gnt_valid,
    output logic [INDEX_WIDTH-1:0] gnt_index,
    output logic [NUM_REQ-1:0]     gnt_onehot,
    input  logic                   gnt_ready,
    output logic                   busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] PTR_INIT   = PTR_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_n;
    logic [PTR_W-1:0]   gnt_idx_q, gnt_idx_n;
    logic [PTR_W-1:0]   last_ptr_q, last_ptr_n;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_n;

    logic               handshake;
    logic [NUM_REQ-1:0] search_vec;
    logic [NUM_REQ-1:0] masked_vec;
    logic [PTR_W-1:0]   search_ptr;
    logic [PTR_W-1:0]   idx_masked, idx_unmasked, search_idx;
    logic               search_hit;
    logic               burst_ok;

    assign handshake = (state_q == GRANT) && gnt_ready;

    // When priority requests exist they shadow the rest; pointer rotation is shared.
`ifdef NOU_SCHED_PRIO_EN
    logic               prio_any;
    assign prio_any   = |(req_vec & prio_vec);
    assign search_vec = prio_any ? (req_vec & prio_vec) : req_vec;
    assign burst_ok   = req_vec[gnt_idx_q] && (burst_cnt_q < BURST_LAST)
                        && !(prio_any && !prio_vec[gnt_idx_q]);
`else
    assign search_vec = req_vec;
    assign burst_ok   = req_vec[gnt_idx_q] && (burst_cnt_q < BURST_LAST);
`endif

    // During a handshake the current grantee is the pointer, so it ends up lowest priority.
    assign search_ptr = (state_q == GRANT) ? gnt_idx_q : last_ptr_q;

    always_comb begin
        masked_vec   = '0;
        idx_masked   = '0;
        idx_unmasked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked_vec[i] = search_vec[i] && (i > int'(search_ptr));
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked_vec[i]) idx_masked   = PTR_W'(i);
            if (search_vec[i]) idx_unmasked = PTR_W'(i);
        end
        search_hit = |search_vec;
        search_idx = (|masked_vec) ? idx_masked : idx_unmasked;
    end

    always_comb begin
        state_n     = state_q;
        gnt_idx_n   = gnt_idx_q;
        last_ptr_n  = last_ptr_q;
        burst_cnt_n = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (search_hit) begin
                    state_n     = GRANT;
                    gnt_idx_n   = search_idx;
                    burst_cnt_n = '0;
                end
            end
            GRANT: begin
                if (handshake) begin
                    if (burst_ok) begin
                        burst_cnt_n = burst_cnt_q + 1'b1;
                    end else begin
                        last_ptr_n  = gnt_idx_q;
                        burst_cnt_n = '0;
                        if (search_hit) begin
                            gnt_idx_n = search_idx;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_idx_q   <= '0;
            last_ptr_q  <= PTR_INIT;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_n;
            gnt_idx_q   <= gnt_idx_n;
            last_ptr_q  <= last_ptr_n;
            burst_cnt_q <= burst_cnt_n;
        end
    end

    assign gnt_valid  = (state_q == GRANT);
    assign busy       = (state_q == GRANT);
    assign gnt_index  = INDEX_WIDTH'(gnt_idx_q);
    assign gnt_onehot = gnt_valid ? (NUM_REQ'(1) << gnt_idx_q) : '0;

endmodule

// File: tb/tb_nou_rr_grant_scheduler.sv
// tb/tb_nou_rr_grant_scheduler.sv - directed-vector bench for nou_rr_grant_scheduler (NUM_REQ=4, MAX_BURST=2)
module tb_nou_rr_grant_scheduler;

    localparam int NR = 4;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req_vec = '0;
    logic [NR-1:0] prio_vec = '0;
    logic          gnt_ready = 1'b0;
    logic          gnt_valid;
    logic [IW-1:0] gnt_index;
    logic [NR-1:0] gnt_onehot;
    logic          busy;

    int checks = 0;
    int failures = 0;

    nou_rr_grant_scheduler #(.NUM_REQ(NR), .MAX_BURST(2), .INDEX_WIDTH(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_vec    (req_vec),
`ifdef NOU_SCHED_PRIO_EN
        .prio_vec   (prio_vec),
`endif
        .gnt_valid  (gnt_valid),
        .gnt_index  (gnt_index),
        .gnt_onehot (gnt_onehot),
        .gnt_ready  (gnt_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_grant(input string tag, input int idx);
        check({tag, ".valid"}, 32'(gnt_valid), 32'd1);
        check({tag, ".index"}, 32'(gnt_index), 32'(idx));
        check({tag, ".onehot"}, 32'(gnt_onehot), 32'(1 << idx));
        check({tag, ".busy"}, 32'(busy), 32'd1);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, 32'(gnt_valid), 32'd0);
        check({tag, ".onehot"}, 32'(gnt_onehot), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // reset state
        @(negedge clk);
        expect_idle("rst");
        check("rst.index", 32'(gnt_index), 32'd0);
        rst_n = 1'b1;

        // alternate between 1 and 3 with no bubble
        req_vec = 4'b1010; gnt_ready = 1'b1;
        step(); expect_grant("alt0", 1);
        req_vec = 4'b1000;
        step(); expect_grant("alt1", 3);
        req_vec = 4'b0010;
        step(); expect_grant("alt2", 1);
        req_vec = 4'b0000;
        step(); expect_idle("alt_end");

        // stall: grant stays put, req_vec changes ignored
        req_vec = 4'b0100; gnt_ready = 1'b0;
        step(); expect_grant("stall0", 2);
        req_vec = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step(); expect_grant($sformatf("stall%0d", i + 1), 2);
        end
        req_vec = 4'b0000; gnt_ready = 1'b1;
        step(); expect_idle("stall_end");

        // burst of two then rotate (pointer at 2 so search wraps to 0)
        req_vec = 4'b0011;
        step(); expect_grant("burst0", 0);
        step(); expect_grant("burst1", 0);
        step(); expect_grant("burst2", 1);
        step(); expect_grant("burst3", 1);
        step(); expect_grant("burst4", 0);
        req_vec = 4'b0000;
        step(); expect_idle("burst_end");

        // single requester 3 drops in its handshake cycle
        req_vec = 4'b1000;
        step(); expect_grant("single0", 3);
        req_vec = 4'b0000;
        step(); expect_idle("single_drop");
        req_vec = 4'b0001;
        step(); expect_grant("wrap0", 0);
        // sole requester at burst limit gets regranted via rotation, then bursts again
        step(); expect_grant("regrant0", 0);
        step(); expect_grant("regrant1", 0);
        step(); expect_grant("regrant2", 0);

        // asynchronous reset mid-grant
        gnt_ready = 1'b0; req_vec = 4'b0100;
        step(); expect_grant("pre_rst", 0);
        #2 rst_n = 1'b0;
        #1 expect_idle("async_rst");
        check("async_rst.index", 32'(gnt_index), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; req_vec = 4'b1111;
        step(); expect_grant("post_rst", 0);

`ifdef NOU_SCHED_PRIO_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; req_vec = 4'b1111; prio_vec = 4'b1000; gnt_ready = 1'b1;
        step(); expect_grant("prio0", 3);
        step(); expect_grant("prio1", 3);
        step(); expect_grant("prio2", 3);
        prio_vec = 4'b0000;
        step(); expect_grant("prio3", 3);
        step(); expect_grant("prio4", 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
